// File: rtl/display_pkg.sv
// Shared constants, state encoding and pixel type for the frame-store read path.
package display_pkg;

    localparam int H_PIXELS     = 110;
    localparam int V_LINES      = 110;
    localparam int BPP          = 24;
    localparam int BYTES_PER_PX = 3;
    localparam int CNT_W        = 10;

    typedef logic [BPP-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND0,
        SEND1,
        SEND2,
        DONE
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Pixel/line position counters for a raster scan; saturate at the last pixel of the frame.
module raster_counter
    import display_pkg::*;
#(
    parameter int H_PIXELS = display_pkg::H_PIXELS,
    parameter int V_LINES  = display_pkg::V_LINES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] px,
    output logic [CNT_W-1:0] line,
    output logic             last_px,
    output logic             last_frame
);

    assign last_px    = (px == CNT_W'(H_PIXELS - 1));
    assign last_frame = last_px && (line == CNT_W'(V_LINES - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            px   <= '0;
            line <= '0;
        end else if (advance && !last_frame) begin
            if (last_px) begin
                px   <= '0;
                line <= line + CNT_W'(1);
            end else begin
                px <= px + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/frame_reader.sv
// Raster-order frame-store reader emitting each 24-bit pixel as R,G,B bytes on a valid/ready stream.
// Optional FRAME_SYNC_EN adds sof/eol framing flags alongside the byte stream.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read strobe for the current pixel
// LATCH | capture read data into the pixel register
// SEND0 | present R byte
// SEND1 | present G byte
// SEND2 | present B byte, then step to next pixel or finish
// DONE  | one-cycle done pulse
module frame_reader
    import display_pkg::*;
#(
    parameter int H_PIXELS = display_pkg::H_PIXELS,
    parameter int V_LINES  = display_pkg::V_LINES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [9:0]  rd_px,
    output logic [9:0]  rd_line,
    input  logic [23:0] rd_data,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
`ifdef FRAME_SYNC_EN
    output logic        sof,
    output logic        eol,
`endif
    output logic [9:0]  PxOut,
    output logic [9:0]  LineOut
);

    state_t           state, state_nx;
    pixel_t           pix;
    logic [CNT_W-1:0] px, line;
    logic             last_px, last_frame;
    logic             cnt_clear, cnt_adv;

    raster_counter #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES)
    ) u_raster (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .advance    (cnt_adv),
        .px         (px),
        .line       (line),
        .last_px    (last_px),
        .last_frame (last_frame)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pix   <= '0;
        end else begin
            state <= state_nx;
            if (state == LATCH) pix <= rd_data;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_clear  = 1'b0;
        cnt_adv    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        byte_valid = 1'b0;
        byte_out   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_clear = 1'b1;
                    state_nx  = FETCH;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                rd_en    = 1'b1;
                state_nx = LATCH;
            end
            LATCH: begin
                busy     = 1'b1;
                state_nx = SEND0;
            end
            SEND0: begin
                busy       = 1'b1;
                byte_valid = 1'b1;
                byte_out   = pix[23:16];
                if (byte_ready) state_nx = SEND1;
            end
            SEND1: begin
                busy       = 1'b1;
                byte_valid = 1'b1;
                byte_out   = pix[15:8];
                if (byte_ready) state_nx = SEND2;
            end
            SEND2: begin
                busy       = 1'b1;
                byte_valid = 1'b1;
                byte_out   = pix[7:0];
                if (byte_ready) begin
                    cnt_adv  = !last_frame;
                    state_nx = last_frame ? DONE : FETCH;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counters only move on SEND2 acceptance, so position outputs hold under backpressure.
    assign rd_px   = px;
    assign rd_line = line;
    assign PxOut   = px;
    assign LineOut = line;

`ifdef FRAME_SYNC_EN
    assign sof = (state == SEND0) && (px == '0) && (line == '0);
    assign eol = (state == SEND2) && last_px;
`endif

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: full 110x110 scan, backpressure, mid-frame reset and a 2x2 instance.
module tb_frame_reader;

    localparam int H     = 110;
    localparam int V     = 110;
    localparam int TOTAL = H * V * 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, byte_ready;
    logic        busy, done, rd_en, byte_valid;
    logic [9:0]  rd_px, rd_line, PxOut, LineOut;
    logic [23:0] rd_data;
    logic [7:0]  byte_out;
`ifdef FRAME_SYNC_EN
    logic        sof, eol, sof_s, eol_s;
`endif

    logic        start_s, ready_s;
    logic        busy_s, done_s, rd_en_s, valid_s;
    logic [9:0]  rd_px_s, rd_line_s, px_s, line_s;
    logic [7:0]  byte_out_s;
    logic [23:0] rd_data_s;
    assign rd_data_s = 24'h112233;

    frame_reader dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_px(rd_px), .rd_line(rd_line), .rd_data(rd_data),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
`ifdef FRAME_SYNC_EN
        .sof(sof), .eol(eol),
`endif
        .PxOut(PxOut), .LineOut(LineOut)
    );

    frame_reader #(.H_PIXELS(2), .V_LINES(2)) dut_small (
        .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
        .rd_en(rd_en_s), .rd_px(rd_px_s), .rd_line(rd_line_s), .rd_data(rd_data_s),
        .byte_out(byte_out_s), .byte_valid(valid_s), .byte_ready(ready_s),
`ifdef FRAME_SYNC_EN
        .sof(sof_s), .eol(eol_s),
`endif
        .PxOut(px_s), .LineOut(line_s)
    );

    // Frame store: one-cycle read latency, contents encode the pixel position.
    always @(posedge clk) if (rd_en) rd_data <= {rd_line[7:0], rd_px[7:0], 8'hA5};

    int errors = 0, checks = 0;
    int cyc = 0, k = 0, f = 0, done_cnt = 0, last_rd = 0, last_acc = -10, t_start = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx);
        int p = idx / 3;
        case (idx % 3)
            0:       return 8'(p / H);
            1:       return 8'(p % H);
            default: return 8'hA5;
        endcase
    endfunction

    function automatic logic [7:0] small_byte(input int idx);
        case (idx % 3)
            0:       return 8'h11;
            1:       return 8'h22;
            default: return 8'h33;
        endcase
    endfunction

    // Runs the main instance cycle by cycle until done, byte index stop_k is presented, or budget expires.
    task automatic run_main(input bit rnd, input int stop_k, input int repulse_k, input int budget);
        bit         stalled = 1'b0;
        bit         ended   = 1'b0;
        logic [7:0] pb      = '0;
        logic [9:0] ppx     = '0;
        logic [9:0] pln     = '0;
        for (int c = 0; c < budget && !ended; c++) begin
            @(posedge clk); #1;
            cyc++;
            start      = 1'b0;
            byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk("hold_valid", byte_valid, 1);
                chk("hold_byte", byte_out, pb);
                chk("hold_px", PxOut, ppx);
                chk("hold_line", LineOut, pln);
            end
            if (rd_en) begin
                if (f == 0) chk("lat_rd_en", cyc, t_start);
                if (f == 4 * H) begin
                    chk("wrap_px", rd_px, 0);
                    chk("wrap_line", rd_line, 4);
                end
                chk("rd_px", rd_px, f % H);
                chk("rd_line", rd_line, f / H);
                if (!rnd && f > 0) chk("px_period", cyc - last_rd, 5);
                last_rd = cyc;
                f++;
            end
`ifdef FRAME_SYNC_EN
            chk("sof", sof, byte_valid && k == 0);
            chk("eol", eol, byte_valid && (k % 3 == 2) && ((k / 3) % H == H - 1));
            if (byte_valid && k == (3 * H + H - 1) * 3 + 2) chk("eol_109_3", eol, 1);
`endif
            if (done) begin
                done_cnt++;
                chk("done_bytes", k, TOTAL);
                chk("done_timing", cyc, last_acc + 1);
                chk("busy_at_done", busy, 0);
                ended = 1'b1;
            end else if (byte_valid) begin
                if (k == 0 && !stalled) chk("lat_valid", cyc, t_start + 2);
                if (k == stop_k) begin
                    ended = 1'b1;
                end else begin
                    chk("busy", busy, 1);
                    chk("byte", byte_out, exp_byte(k));
                    chk("px_out", PxOut, (k / 3) % H);
                    chk("line_out", LineOut, (k / 3) / H);
                    if (byte_ready) begin
                        last_acc = cyc;
                        k++;
                        stalled = 1'b0;
                        if (k == repulse_k) start = 1'b1;
                    end else begin
                        stalled = 1'b1;
                        pb  = byte_out;
                        ppx = PxOut;
                        pln = LineOut;
                    end
                end
            end else begin
                stalled = 1'b0;
            end
        end
        chk("run_completed", ended, 1);
    endtask

    task automatic launch();
        k = 0; f = 0; last_acc = -10;
        t_start = cyc + 1;
        start   = 1'b1;
    endtask

    initial begin
        int n = 0, sacc = -10, sdone = 0;
        reset = 1'b0; start = 1'b0; byte_ready = 1'b0;
        start_s = 1'b0; ready_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", byte_valid, 0);
        chk("rst_byte", byte_out, 0);
        chk("rst_px_out", PxOut, 0);
        chk("rst_line_out", LineOut, 0);
        chk("rst_rd_px", rd_px, 0);
        chk("rst_rd_line", rd_line, 0);
        reset = 1'b1;
        @(posedge clk); #1; cyc++;
        chk("idle_ready_no_effect", byte_valid, 0);

        // Full frame, ready held high, start re-pulsed at byte 100.
        launch();
        run_main(1'b0, -1, 100, 62000);
        @(posedge clk); #1; cyc++;
        chk("done_single_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 1);
        chk("idle_valid", byte_valid, 0);

        // Random backpressure, then reset during SEND1 of pixel (5,2).
        launch();
        run_main(1'b1, (2 * H + 5) * 3 + 1, -1, 8000);
        chk("stop_px", PxOut, 5);
        chk("stop_line", LineOut, 2);
        chk("stop_byte", byte_out, 8'd5);
        reset = 1'b0;
        @(posedge clk); #1; cyc++;
        chk("mid_rst_valid", byte_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1; cyc++;
            chk("mid_rst_no_done", done, 0);
        end
        chk("mid_rst_done_count", done_cnt, 1);

        // New frame after reset must restart at (0,0).
        launch();
        run_main(1'b0, 9, -1, 200);
        chk("restart_px", PxOut, 3);
        chk("restart_line", LineOut, 0);
        reset = 1'b0;
        @(posedge clk); #1; cyc++;
        reset = 1'b1;

        // 2x2 instance with constant pixel data.
        start_s = 1'b1;
        for (int c = 0; c < 200 && sdone == 0; c++) begin
            @(posedge clk); #1; cyc++;
            start_s = 1'b0;
            if (done_s) begin
                sdone++;
                chk("s_count", n, 12);
                chk("s_done_timing", cyc, sacc + 1);
            end else if (valid_s) begin
                chk("s_byte", byte_out_s, small_byte(n));
                chk("s_px", px_s, (n / 3) % 2);
                chk("s_line", line_s, (n / 3) / 2);
                sacc = cyc;
                n++;
            end
            if (rd_en_s) chk("s_rd_pos", {rd_line_s, rd_px_s}, {10'((n / 3) / 2), 10'((n / 3) % 2)});
        end
        chk("s_done_seen", sdone, 1);
        @(posedge clk); #1; cyc++;
        chk("s_done_once", done_s, 0);
        chk("s_busy_after", busy_s, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Raster-order read side of the 110x110, 24-bpp frame store.
- Scans lines 0..V_LINES-1 and pixels 0..H_PIXELS-1. Fetches each 24-bit pixel from the frame-store read port and emits it as three bytes (R, G, B) on a valid/ready byte stream.
- This is the byte-stream inverse of the write-side pixel assembler. It feeds the display output adapter.

Parameters:
- H_PIXELS, 110, pixels per line.
- V_LINES, 110, lines per frame.
- BPP, 24, bits per pixel; fixed at 3 bytes.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a frame scan
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last byte of the frame is accepted
- rd_en  out  1  frame-store read strobe
- rd_px  out  10  pixel index of the read
- rd_line  out  10  line index of the read
- rd_data  in  24  pixel data, valid exactly 1 cycle after rd_en
- byte_out  out  8  stream byte
- byte_valid  out  1  byte_out is valid
- byte_ready  in  1  downstream accepts when valid && ready
- PxOut  out  10  pixel index of the byte currently presented
- LineOut  out  10  line index of the byte currently presented

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE; busy, done, rd_en and byte_valid = 0; byte_out=0; PxOut, LineOut, rd_px, rd_line = 0.
- FSM states:
  - IDLE: on start, clear px/line counters, set busy, go to FETCH.
  - FETCH: assert rd_en for 1 cycle with rd_px/rd_line = current counters, go to LATCH.
  - LATCH: capture rd_data into the pixel register, go to SEND0.
  - SEND0: present pix[23:16].
  - SEND1: present pix[15:8].
  - SEND2: present pix[7:0].
- Advance rule: each SENDn holds byte_valid=1. It advances only on valid && ready. byte_out, PxOut and LineOut stay stable while valid && !ready.
- After SEND2 is accepted:
  - If px < H_PIXELS-1: px += 1, go to FETCH.
  - Else px = 0. If line < V_LINES-1: line += 1, go to FETCH.
  - Else (last pixel of the frame): go to DONE.
- DONE: pulse done for 1 cycle, clear busy, go to IDLE.
- Latency: start seen at edge T gives rd_en high in cycle T+1 and byte_valid high in cycle T+3.
- Throughput: best case 5 cycles per pixel (FETCH, LATCH, 3x SEND) with ready held high.
- byte_valid drops to 0 during FETCH and LATCH.
- start while busy: ignored, no restart.
- start in the same cycle as done: ignored; a new start is needed once in IDLE.
- Reset mid-frame: immediate return to IDLE. The in-flight byte is dropped, byte_valid=0, and no done pulse.
- Counters are 10 bits and compare against H_PIXELS-1 and V_LINES-1. They never exceed these values, so there is no wrap beyond the frame.
- byte_ready while byte_valid=0: no effect.

Optional Feature:
- Macro: FRAME_SYNC_EN.
- When defined, two extra outputs are added: sof (1 bit) and eol (1 bit), both qualified by byte_valid.
  - sof=1 on the R byte of pixel (0,0).
  - eol=1 on the B byte of pixel H_PIXELS-1 of every line.
  - Both hold stable under backpressure like byte_out.
- When not defined, the ports do not exist. The rest of the behaviour is identical.

Decomposition:
- Package display_pkg holds:
  - constants H_PIXELS=110, V_LINES=110, BPP=24, BYTES_PER_PX=3, CNT_W=10;
  - the FSM state enum (IDLE, FETCH, LATCH, SEND0, SEND1, SEND2, DONE);
  - typedef pixel_t (24 bits).
- One natural sub-module: raster_counter. It holds the px/line counters with advance, last_px and last_frame outputs, parameterised by H_PIXELS and V_LINES.
- The byte mux and FSM stay in frame_reader.

Test Plan:
- Reset then start, ready tied 1, memory returns {line[7:0], px[7:0], 8'hA5} -> bytes for pixel (0,0) are 00,00,A5; rd_en in cycle T+1 and first byte_valid in cycle T+3; 5 cycles per pixel; total 36300 bytes; done pulses exactly once; busy low after.
- Ready toggled with a random 50% pattern -> byte_out, PxOut and LineOut never change while valid && !ready; byte sequence identical to the ready=1 run.
- Line wrap: observe pixel 109 of line 3 -> next rd_en has rd_px=0, rd_line=4; with FRAME_SYNC_EN, eol=1 on the B byte of (109,3) only.
- Start pulsed again at byte 100 of the frame -> ignored; counters continue; a single done pulse at frame end.
- reset=0 asserted during SEND1 of pixel (5,2), then released, then start -> byte_valid=0 the cycle after reset, no done pulse; the new frame begins at (0,0) with sof=1 on its first byte when FRAME_SYNC_EN is defined.
- Small config H_PIXELS=2, V_LINES=2, rd_data=24'h112233 -> exact stream 11 22 33 repeated 4 times; done pulses 1 cycle after the 12th byte is accepted.
